// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: runs search, read, write, fill and invalidate
// operations against an external, combinationally read TLB array.
module tlb_maint_ctrl #(
  parameter int TLBNUM     = 16,
  parameter int TLBNUMSIZE = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic                  flush,
  input  logic [4:0]            inv_op,
  input  logic [9:0]            op_asid,
  input  logic [18:0]           op_va,
  input  logic [TLBNUMSIZE-1:0] csr_idx,
  input  logic [88:0]           wr_entry,
  output logic [TLBNUMSIZE-1:0] tlb_rd_idx,
  input  logic [88:0]           tlb_rd_entry,
  output logic                  tlb_we,
  output logic [TLBNUMSIZE-1:0] tlb_w_idx,
  output logic [88:0]           tlb_w_entry,
  output logic                  done,
  output logic                  srch_hit,
  output logic [TLBNUMSIZE-1:0] res_idx,
  output logic [88:0]           rd_entry,
  output logic                  rd_ne,
  output logic                  inv_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    WALK   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;
  localparam logic [TLBNUMSIZE-1:0] LAST_IDX = TLBNUMSIZE'(TLBNUM - 1);

  state_t                  state_r;
  state_t                  state_next_s;
  logic [2:0]              op_r;
  logic [4:0]              inv_op_r;
  logic [9:0]              asid_r;
  logic [18:0]             va_r;
  logic [TLBNUMSIZE-1:0]   csr_idx_r;
  logic [88:0]             wr_entry_r;
  logic [TLBNUMSIZE-1:0]   fill_cnt_r;
  logic [TLBNUMSIZE-1:0]   fill_idx_r;
  logic [TLBNUMSIZE-1:0]   k_r;

  logic                    accept_s;
  logic                    bad_s;
  logic                    single_op_s;
  logic                    va_match_s;
  logic                    asid_match_s;
  logic                    srch_match_s;
  logic                    inv_match_s;
  logic                    walk_end_s;

  assign req_ready   = (state_r == IDLE);
  assign done        = (state_r == DONE);
  assign accept_s    = req_valid && (state_r == IDLE) && !flush;
  assign bad_s       = (req_op > OP_INV) || ((req_op == OP_INV) && (inv_op > 5'd6));
  assign single_op_s = (req_op == OP_RD) || (req_op == OP_WR) || (req_op == OP_FILL);

  // Match terms for the entry currently presented on the read port
  always_comb begin
    asid_match_s = (tlb_rd_entry[87:78] == asid_r);
    if (tlb_rd_entry[76:71] == 6'd21) begin
      va_match_s = (tlb_rd_entry[70:61] == va_r[18:9]);
    end else begin
      va_match_s = (tlb_rd_entry[70:52] == va_r);
    end
    srch_match_s = tlb_rd_entry[88] && (tlb_rd_entry[77] || asid_match_s) && va_match_s;
    case (inv_op_r)
      5'd0, 5'd1: inv_match_s = 1'b1;
      5'd2:       inv_match_s = tlb_rd_entry[77];
      5'd3:       inv_match_s = !tlb_rd_entry[77];
      5'd4:       inv_match_s = !tlb_rd_entry[77] && asid_match_s;
      5'd5:       inv_match_s = !tlb_rd_entry[77] && asid_match_s && va_match_s;
      5'd6:       inv_match_s = (tlb_rd_entry[77] || asid_match_s) && va_match_s;
      default:    inv_match_s = 1'b0;
    endcase
    walk_end_s = (k_r == LAST_IDX) || ((op_r == OP_SRCH) && srch_match_s);
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_next_s = IDLE;
        end else if (bad_s) begin
          state_next_s = DONE;
        end else if (single_op_s) begin
          state_next_s = SINGLE;
        end else begin
          state_next_s = WALK;
        end
      end
      SINGLE:  state_next_s = DONE;
      WALK: begin
        if (walk_end_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = WALK;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Array port drive; writes for invalidate go out in the cycle the match is seen
  always_comb begin
    tlb_rd_idx  = '0;
    tlb_we      = 1'b0;
    tlb_w_idx   = '0;
    tlb_w_entry = 89'd0;
    case (state_r)
      SINGLE: begin
        tlb_rd_idx = csr_idx_r;
        if ((op_r == OP_WR) || (op_r == OP_FILL)) begin
          tlb_we      = 1'b1;
          tlb_w_idx   = (op_r == OP_FILL) ? fill_idx_r : csr_idx_r;
          tlb_w_entry = wr_entry_r;
        end else begin
          tlb_we = 1'b0;
        end
      end
      WALK: begin
        tlb_rd_idx = k_r;
        if ((op_r == OP_INV) && inv_match_s) begin
          tlb_we      = 1'b1;
          tlb_w_idx   = k_r;
          tlb_w_entry = {1'b0, tlb_rd_entry[87:0]};
        end else begin
          tlb_we = 1'b0;
        end
      end
      default: tlb_rd_idx = '0;
    endcase
  end

  // Free-running fill pointer, wraps at the last entry
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fill_cnt_r <= '0;
    end else if (fill_cnt_r == LAST_IDX) begin
      fill_cnt_r <= '0;
    end else begin
      fill_cnt_r <= fill_cnt_r + TLBNUMSIZE'(1);
    end
  end

  // State, latched request and result registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r    <= IDLE;
      op_r       <= 3'd0;
      inv_op_r   <= 5'd0;
      asid_r     <= 10'd0;
      va_r       <= 19'd0;
      csr_idx_r  <= '0;
      wr_entry_r <= 89'd0;
      fill_idx_r <= '0;
      k_r        <= '0;
      srch_hit   <= 1'b0;
      res_idx    <= '0;
      rd_entry   <= 89'd0;
      rd_ne      <= 1'b0;
      inv_err    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        op_r       <= req_op;
        inv_op_r   <= inv_op;
        asid_r     <= op_asid;
        va_r       <= op_va;
        csr_idx_r  <= csr_idx;
        wr_entry_r <= wr_entry;
        fill_idx_r <= fill_cnt_r;
        k_r        <= '0;
        if (bad_s) begin
          inv_err  <= 1'b1;
          srch_hit <= 1'b0;
          res_idx  <= '0;
        end
      end
      if (state_r == SINGLE) begin
        inv_err  <= 1'b0;
        srch_hit <= 1'b0;
        res_idx  <= (op_r == OP_FILL) ? fill_idx_r : csr_idx_r;
        if (op_r == OP_RD) begin
          rd_entry <= tlb_rd_entry;
          rd_ne    <= ~tlb_rd_entry[88];
        end
      end
      if (state_r == WALK) begin
        if (walk_end_s) begin
          inv_err  <= 1'b0;
          srch_hit <= (op_r == OP_SRCH) && srch_match_s;
          res_idx  <= ((op_r == OP_SRCH) && srch_match_s) ? k_r : '0;
        end else begin
          k_r <= k_r + TLBNUMSIZE'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Directed bench for tlb_maint_ctrl: a vector table of single operations
// plus hand-written fill-wrap, reset-abort and flush sequences.
module tb_tlb_maint_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        flush;
  logic [4:0]  inv_op;
  logic [9:0]  op_asid;
  logic [18:0] op_va;
  logic [3:0]  csr_idx;
  logic [88:0] wr_entry;
  logic [3:0]  tlb_rd_idx;
  logic [88:0] tlb_rd_entry;
  logic        tlb_we;
  logic [3:0]  tlb_w_idx;
  logic [88:0] tlb_w_entry;
  logic        done;
  logic        srch_hit;
  logic [3:0]  res_idx;
  logic [88:0] rd_entry;
  logic        rd_ne;
  logic        inv_err;

  logic [88:0] tlb_mem [16];
  logic [88:0] ld_img  [16];
  logic        ld_en;

  int n_vec = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  tlb_maint_ctrl #(.TLBNUM(16), .TLBNUMSIZE(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .flush(flush), .inv_op(inv_op), .op_asid(op_asid), .op_va(op_va),
    .csr_idx(csr_idx), .wr_entry(wr_entry), .tlb_rd_idx(tlb_rd_idx),
    .tlb_rd_entry(tlb_rd_entry), .tlb_we(tlb_we), .tlb_w_idx(tlb_w_idx),
    .tlb_w_entry(tlb_w_entry), .done(done), .srch_hit(srch_hit), .res_idx(res_idx),
    .rd_entry(rd_entry), .rd_ne(rd_ne), .inv_err(inv_err)
  );

  // TLB array model: combinational read, write on clock edge
  assign tlb_rd_entry = tlb_mem[tlb_rd_idx];
  always @(posedge aclk) begin
    if (ld_en) begin
      for (int i = 0; i < 16; i++) tlb_mem[i] <= ld_img[i];
    end else if (tlb_we) begin
      tlb_mem[tlb_w_idx] <= tlb_w_entry;
    end
  end

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  iop;
    logic [9:0]  asid;
    logic [18:0] va;
    logic [3:0]  idx;
    logic [88:0] wen;
    logic [7:0]  lat;
    logic        hit;
    logic [3:0]  res;
    logic        err;
    logic [7:0]  wcnt;
    logic [3:0]  widx;
    logic        chk_res;
    logic        chk_rd;
    logic [88:0] rde;
    logic        ne;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [88:0] ent(input logic e, input logic [9:0] asid, input logic g,
                                      input logic [5:0] ps, input logic [18:0] vppn);
    return {e, asid, g, ps, vppn, 52'd0};
  endfunction

  function automatic vec_t mkv(input logic [2:0] op, input logic [4:0] iop,
                               input logic [9:0] asid, input logic [18:0] va,
                               input logic [3:0] idx, input logic [88:0] wen,
                               input int lat, input logic hit, input logic [3:0] res,
                               input logic err, input int wcnt, input logic [3:0] widx,
                               input logic chk_res, input logic chk_rd,
                               input logic [88:0] rde, input logic ne);
    vec_t v;
    v.op = op; v.iop = iop; v.asid = asid; v.va = va; v.idx = idx; v.wen = wen;
    v.lat = 8'(lat); v.hit = hit; v.res = res; v.err = err; v.wcnt = 8'(wcnt);
    v.widx = widx; v.chk_res = chk_res; v.chk_rd = chk_rd; v.rde = rde; v.ne = ne;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [88:0] act, input logic [88:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_img();
    ld_en = 1'b1;
    @(posedge aclk);
    #1 ld_en = 1'b0;
    @(negedge aclk);
  endtask

  // Issue one op at a negedge; latency counts cycles from the accept cycle to done
  task automatic run_op(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] asid,
                        input logic [18:0] va, input logic [3:0] idx, input logic [88:0] wen,
                        output int lat, output int wcnt, output logic [3:0] widx,
                        output logic rdy_done);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge aclk);
      guard++;
    end
    req_valid = 1'b1; req_op = op; inv_op = iop; op_asid = asid; op_va = va;
    csr_idx = idx; wr_entry = wen;
    @(negedge aclk);
    req_valid = 1'b0;
    lat = 1; wcnt = 0; widx = 4'd0;
    while (!done && lat < 100) begin
      if (tlb_we) begin
        wcnt++;
        widx = tlb_w_idx;
      end
      @(negedge aclk);
      lat++;
    end
    if (tlb_we) wcnt++;
    rdy_done = req_ready;
  endtask

  int          lat;
  int          wcnt;
  logic [3:0]  widx;
  logic        rdy;
  logic [88:0] e5, e9, e2, e9inv, wr7, f1, f2;
  int          n_done;
  int          n_we;
  int          n_busy;

  initial begin
    aresetn = 1'b0; req_valid = 1'b0; req_op = 3'd0; flush = 1'b0; inv_op = 5'd0;
    op_asid = 10'd0; op_va = 19'd0; csr_idx = 4'd0; wr_entry = 89'd0; ld_en = 1'b0;

    e2    = ent(1'b1, 10'h055, 1'b1, 6'd12, 19'h00777);
    e5    = ent(1'b1, 10'h012, 1'b0, 6'd12, 19'h01234);
    e9    = ent(1'b1, 10'h003, 1'b0, 6'd12, 19'h02222);
    e9inv = ent(1'b0, 10'h003, 1'b0, 6'd12, 19'h02222);
    wr7   = ent(1'b1, 10'h021, 1'b0, 6'd12, 19'h04444);
    f1    = ent(1'b1, 10'h077, 1'b0, 6'd12, 19'h05555);
    f2    = ent(1'b1, 10'h078, 1'b0, 6'd12, 19'h06666);

    for (int i = 0; i < 16; i++) ld_img[i] = ent(1'b0, 10'h3FF, 1'b1, 6'd12, 19'h0);
    ld_img[2]  = e2;
    ld_img[5]  = e5;
    ld_img[9]  = e9;
    ld_img[12] = ent(1'b1, 10'h040, 1'b0, 6'd21, 19'h2A5FF);
    load_img();

    #1;
    chk("rst done", 89'(done), 89'd0);
    chk("rst tlb_we", 89'(tlb_we), 89'd0);
    chk("rst results", {srch_hit, res_idx, rd_ne, inv_err}, 89'd0);
    chk("rst rd_entry", rd_entry, 89'd0);
    chk("rst idx", {tlb_rd_idx, tlb_w_idx}, 89'd0);
    chk("rst w_entry", tlb_w_entry, 89'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("ready after release", 89'(req_ready), 89'd1);

    //          op    iop    asid     va         idx   wen    lat hit res  err wc widx cr crd rde    ne
    vecs[0]  = mkv(3'd0, 5'd0, 10'h012, 19'h01234, 4'd0, 89'd0, 7,  1, 4'd5, 0, 0, 4'd0, 1, 0, 89'd0, 0);
    vecs[1]  = mkv(3'd0, 5'd0, 10'h013, 19'h01234, 4'd0, 89'd0, 17, 0, 4'd0, 0, 0, 4'd0, 1, 0, 89'd0, 0);
    vecs[2]  = mkv(3'd0, 5'd0, 10'h099, 19'h00777, 4'd0, 89'd0, 4,  1, 4'd2, 0, 0, 4'd0, 1, 0, 89'd0, 0);
    vecs[3]  = mkv(3'd0, 5'd0, 10'h040, 19'h2A400, 4'd0, 89'd0, 14, 1, 4'd12,0, 0, 4'd0, 1, 0, 89'd0, 0);
    vecs[4]  = mkv(3'd0, 5'd0, 10'h012, 19'h01200, 4'd0, 89'd0, 17, 0, 4'd0, 0, 0, 4'd0, 1, 0, 89'd0, 0);
    vecs[5]  = mkv(3'd1, 5'd0, 10'h000, 19'h00000, 4'd5, 89'd0, 2,  0, 4'd5, 0, 0, 4'd0, 1, 1, e5,    0);
    vecs[6]  = mkv(3'd4, 5'd4, 10'h003, 19'h00000, 4'd0, 89'd0, 17, 0, 4'd0, 0, 1, 4'd9, 0, 0, 89'd0, 0);
    vecs[7]  = mkv(3'd4, 5'd7, 10'h003, 19'h00000, 4'd0, 89'd0, 1,  0, 4'd0, 1, 0, 4'd0, 0, 0, 89'd0, 0);
    vecs[8]  = mkv(3'd1, 5'd0, 10'h000, 19'h00000, 4'd9, 89'd0, 2,  0, 4'd9, 0, 0, 4'd0, 1, 1, e9inv, 1);
    vecs[9]  = mkv(3'd5, 5'd0, 10'h000, 19'h00000, 4'd0, 89'd0, 1,  0, 4'd0, 1, 0, 4'd0, 0, 0, 89'd0, 0);
    vecs[10] = mkv(3'd2, 5'd0, 10'h000, 19'h00000, 4'd7, wr7,   2,  0, 4'd0, 0, 1, 4'd7, 0, 0, 89'd0, 0);
    vecs[11] = mkv(3'd0, 5'd0, 10'h021, 19'h04444, 4'd0, 89'd0, 9,  1, 4'd7, 0, 0, 4'd0, 1, 0, 89'd0, 0);
    vecs[12] = mkv(3'd4, 5'd6, 10'h055, 19'h00777, 4'd0, 89'd0, 17, 0, 4'd0, 0, 1, 4'd2, 0, 0, 89'd0, 0);
    vecs[13] = mkv(3'd4, 5'd5, 10'h012, 19'h01234, 4'd0, 89'd0, 17, 0, 4'd0, 0, 1, 4'd5, 0, 0, 89'd0, 0);
    vecs[14] = mkv(3'd4, 5'd2, 10'h000, 19'h00000, 4'd0, 89'd0, 17, 0, 4'd0, 0, 12,4'd15,0, 0, 89'd0, 0);
    vecs[15] = mkv(3'd4, 5'd0, 10'h000, 19'h00000, 4'd0, 89'd0, 17, 0, 4'd0, 0, 16,4'd15,0, 0, 89'd0, 0);

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].iop, vecs[i].asid, vecs[i].va, vecs[i].idx, vecs[i].wen,
             lat, wcnt, widx, rdy);
      chk($sformatf("v%0d latency", i), 89'(lat), 89'(vecs[i].lat));
      chk($sformatf("v%0d inv_err", i), 89'(inv_err), 89'(vecs[i].err));
      chk($sformatf("v%0d we count", i), 89'(wcnt), 89'(vecs[i].wcnt));
      chk($sformatf("v%0d ready in done", i), 89'(rdy), 89'd0);
      if (vecs[i].wcnt != 8'd0) chk($sformatf("v%0d w_idx", i), 89'(widx), 89'(vecs[i].widx));
      if (vecs[i].chk_res) chk($sformatf("v%0d res_idx", i), 89'(res_idx), 89'(vecs[i].res));
      if (vecs[i].op == 3'd0) chk($sformatf("v%0d srch_hit", i), 89'(srch_hit), 89'(vecs[i].hit));
      if (vecs[i].chk_rd) begin
        chk($sformatf("v%0d rd_entry", i), rd_entry, vecs[i].rde);
        chk($sformatf("v%0d rd_ne", i), 89'(rd_ne), 89'(vecs[i].ne));
      end
      if (i == 6) chk("v6 entry9 cleared", tlb_mem[9], e9inv);
      if (i == 10) chk("v10 entry7 written", tlb_mem[7], wr7);
    end
    chk("all invalid after inv0", 89'(tlb_mem[7][88] | tlb_mem[12][88] | tlb_mem[0][88]), 89'd0);

    // G=0 invalidate on a two-entry array
    for (int i = 0; i < 16; i++) ld_img[i] = ent(1'b0, 10'h3FF, 1'b1, 6'd12, 19'h0);
    ld_img[2] = e2;
    ld_img[9] = e9;
    load_img();
    run_op(3'd4, 5'd7, 10'h003, 19'h0, 4'd0, 89'd0, lat, wcnt, widx, rdy);
    chk("bad inv err", 89'(inv_err), 89'd1);
    run_op(3'd4, 5'd3, 10'h003, 19'h0, 4'd0, 89'd0, lat, wcnt, widx, rdy);
    chk("inv3 latency", 89'(lat), 89'd17);
    chk("inv3 we count", 89'(wcnt), 89'd1);
    chk("inv3 w_idx", 89'(widx), 89'd9);
    chk("inv3 inv_err", 89'(inv_err), 89'd0);
    chk("inv3 entry9", tlb_mem[9], e9inv);
    chk("inv3 entry2", tlb_mem[2], e2);

    // Fill pointer wrap: accept on the 16th edge after release samples 15
    aresetn = 1'b0;
    #1;
    chk("mid rst rd_entry", rd_entry, 89'd0);
    chk("mid rst res", {srch_hit, res_idx, rd_ne, inv_err}, 89'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (15) @(posedge aclk);
    @(negedge aclk);
    run_op(3'd3, 5'd0, 10'h0, 19'h0, 4'd3, f1, lat, wcnt, widx, rdy);
    chk("fill15 latency", 89'(lat), 89'd2);
    chk("fill15 we count", 89'(wcnt), 89'd1);
    chk("fill15 w_idx", 89'(widx), 89'd15);
    chk("fill15 res_idx", 89'(res_idx), 89'd15);
    run_op(3'd3, 5'd0, 10'h0, 19'h0, 4'd3, f2, lat, wcnt, widx, rdy);
    chk("fill wrap w_idx", 89'(widx), 89'd2);
    chk("fill wrap res_idx", 89'(res_idx), 89'd2);
    chk("fill15 entry", tlb_mem[15], f1);
    chk("fill wrap entry", tlb_mem[2], f2);

    // Reset while an invalidate-all walk is at entry 6
    for (int i = 0; i < 16; i++) ld_img[i] = ent(1'b1, 10'h3FF, 1'b1, 6'd12, 19'h0);
    load_img();
    req_valid = 1'b1; req_op = 3'd4; inv_op = 5'd0;
    @(negedge aclk);
    req_valid = 1'b0;
    lat = 1;
    while (tlb_rd_idx != 4'd6 && lat < 30) begin
      @(negedge aclk);
      lat++;
    end
    chk("walk reaches k6", 89'(lat), 89'd7);
    aresetn = 1'b0;
    #1;
    chk("abort tlb_we", 89'(tlb_we), 89'd0);
    chk("abort done", 89'(done), 89'd0);
    n_done = 0; n_we = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (20) begin
      @(negedge aclk);
      if (done) n_done++;
      if (tlb_we) n_we++;
    end
    chk("abort no done", 89'(n_done), 89'd0);
    chk("abort no we", 89'(n_we), 89'd0);
    chk("abort ready", 89'(req_ready), 89'd1);
    chk("abort entry5 cleared", 89'(tlb_mem[5][88]), 89'd0);
    chk("abort entry6 kept", 89'(tlb_mem[6][88]), 89'd1);

    // Flush held with a request: nothing is accepted
    req_valid = 1'b1; flush = 1'b1; req_op = 3'd2; csr_idx = 4'd4; wr_entry = f1;
    n_done = 0; n_we = 0; n_busy = 0;
    repeat (5) begin
      @(negedge aclk);
      if (done) n_done++;
      if (tlb_we) n_we++;
      if (!req_ready) n_busy++;
    end
    req_valid = 1'b0; flush = 1'b0;
    chk("flush no accept", 89'(n_busy), 89'd0);
    chk("flush no done", 89'(n_done), 89'd0);
    chk("flush no we", 89'(n_we), 89'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
